// File: rtl/traffic_lamp_monitor.sv
// Lamp decoder and conflict monitor behind the traffic light controller.
// Latency: 1 cycle from accepted light code to lamp drive; faults act on the same edge.
// Backpressure: none; inputs are sampled every cycle, and in FAULT they are ignored until fault_clr.
// Optional build macro LAMP_FAULT_YELLOW_EN: main lamp flashes yellow instead of red while faulted.
module traffic_lamp_monitor #(
  parameter int BLINK_HALF  = 4,
  parameter int MIN_YELLOW  = 3,
  parameter int ALL_RED_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] main_light,
  input  logic [1:0] side_light,
  input  logic       fault_clr,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       fault,
  output logic [2:0] fault_cause
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int SW = (ALL_RED_CYC > 1) ? $clog2(ALL_RED_CYC) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [YW-1:0] Y_MAX   = YW'(MIN_YELLOW);
  localparam logic [SW-1:0] ST_LAST = SW'(ALL_RED_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

  localparam logic [1:0] CODE_R   = 2'b00;
  localparam logic [1:0] CODE_Y   = 2'b01;
  localparam logic [1:0] CODE_G   = 2'b10;
  localparam logic [1:0] CODE_ILL = 2'b11;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

`ifdef LAMP_FAULT_YELLOW_EN
  localparam logic [2:0] FLASH_MAIN = LAMP_Y;
`else
  localparam logic [2:0] FLASH_MAIN = LAMP_R;
`endif
  localparam logic [2:0] FLASH_SIDE = LAMP_R;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_NORMAL  = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   st_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_on;
  logic [1:0]      main_q;
  logic [1:0]      side_q;
  logic [YW-1:0]   main_ycnt;
  logic [YW-1:0]   side_ycnt;

  logic [2:0]      cause_now;
  logic [YW-1:0]   main_ycnt_nxt;
  logic [YW-1:0]   side_ycnt_nxt;

  // Code to one-hot {R,Y,G}; the illegal code is never presented here.
  function automatic logic [2:0] decode(input logic [1:0] code);
    logic [2:0] lamp;
    case (code)
      CODE_R:  lamp = LAMP_R;
      CODE_Y:  lamp = LAMP_Y;
      CODE_G:  lamp = LAMP_G;
      default: lamp = LAMP_R;
    endcase
    return lamp;
  endfunction

  // True when prev->nxt is not an allowed step of the light cycle.
  // An illegal new code is left to the illegal-code check.
  function automatic logic seq_bad(input logic [1:0]    prev,
                                   input logic [1:0]    nxt,
                                   input logic [YW-1:0] ycnt);
    logic ok;
    ok = 1'b0;
    if (nxt == CODE_ILL) begin
      ok = 1'b1;
    end else begin
      case (prev)
        CODE_R:  ok = (nxt == CODE_R) || (nxt == CODE_G);
        CODE_G:  ok = (nxt == CODE_G) || (nxt == CODE_Y);
        CODE_Y:  ok = (nxt == CODE_Y) || ((nxt == CODE_R) && (ycnt >= Y_MAX));
        default: ok = 1'b0;
      endcase
    end
    return !ok;
  endfunction

  // Length of the current yellow run, saturating once Y->R becomes legal.
  function automatic logic [YW-1:0] ycnt_step(input logic [1:0]    prev,
                                              input logic [1:0]    nxt,
                                              input logic [YW-1:0] ycnt);
    logic [YW-1:0] res;
    if (nxt != CODE_Y) begin
      res = '0;
    end else if (prev != CODE_Y) begin
      res = YW'(1);
    end else if (ycnt == Y_MAX) begin
      res = ycnt;
    end else begin
      res = ycnt + 1'b1;
    end
    return res;
  endfunction

  // Check the raw inputs against the last accepted codes.
  always_comb begin
    cause_now     = 3'b000;
    cause_now[0]  = (main_light != CODE_R) && (side_light != CODE_R);
    cause_now[1]  = (main_light == CODE_ILL) || (side_light == CODE_ILL);
    cause_now[2]  = seq_bad(main_q, main_light, main_ycnt) ||
                    seq_bad(side_q, side_light, side_ycnt);
    main_ycnt_nxt = ycnt_step(main_q, main_light, main_ycnt);
    side_ycnt_nxt = ycnt_step(side_q, side_light, side_ycnt);
  end

  // Monitor state machine with registered lamp, fault and cause outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_STARTUP;
      st_cnt      <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b0;
      main_q      <= CODE_R;
      side_q      <= CODE_R;
      main_ycnt   <= '0;
      side_ycnt   <= '0;
      main_lamp   <= LAMP_R;
      side_lamp   <= LAMP_R;
      fault       <= 1'b0;
      fault_cause <= 3'b000;
    end else begin
      case (state)
        ST_STARTUP: begin
          main_lamp <= LAMP_R;
          side_lamp <= LAMP_R;
          main_q    <= CODE_R;
          side_q    <= CODE_R;
          if (st_cnt == ST_LAST) begin
            st_cnt <= '0;
            state  <= ST_NORMAL;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end

        ST_NORMAL: begin
          if (|cause_now) begin
            // Offending codes are dropped; the lamps go straight to the flash-on pattern.
            state       <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= cause_now;
            main_lamp   <= FLASH_MAIN;
            side_lamp   <= FLASH_SIDE;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
          end else begin
            main_q    <= main_light;
            side_q    <= side_light;
            main_ycnt <= main_ycnt_nxt;
            side_ycnt <= side_ycnt_nxt;
            main_lamp <= decode(main_light);
            side_lamp <= decode(side_light);
          end
        end

        ST_FAULT: begin
          if (fault_clr) begin
            state       <= ST_STARTUP;
            fault       <= 1'b0;
            fault_cause <= 3'b000;
            main_lamp   <= LAMP_R;
            side_lamp   <= LAMP_R;
            main_q      <= CODE_R;
            side_q      <= CODE_R;
            main_ycnt   <= '0;
            side_ycnt   <= '0;
            st_cnt      <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b0;
          end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
            main_lamp <= blink_on ? LAMP_OFF : FLASH_MAIN;
            side_lamp <= blink_on ? LAMP_OFF : FLASH_SIDE;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end

        default: begin
          state       <= ST_STARTUP;
          st_cnt      <= '0;
          blink_cnt   <= '0;
          blink_on    <= 1'b0;
          main_q      <= CODE_R;
          side_q      <= CODE_R;
          main_ycnt   <= '0;
          side_ycnt   <= '0;
          main_lamp   <= LAMP_R;
          side_lamp   <= LAMP_R;
          fault       <= 1'b0;
          fault_cause <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: directed scenarios plus random codes against a rule-level model.
module tb_traffic_lamp_monitor;

  localparam int BH = 4;
  localparam int MY = 3;
  localparam int AR = 2;

`ifdef LAMP_FAULT_YELLOW_EN
  localparam logic [2:0] FM = 3'b010;
`else
  localparam logic [2:0] FM = 3'b100;
`endif
  localparam logic [2:0] FS = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] main_light = 2'b00;
  logic [1:0] side_light = 2'b00;
  logic       fault_clr = 1'b0;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       fault;
  logic [2:0] fault_cause;
  logic [9:0] obs;

  traffic_lamp_monitor #(.BLINK_HALF(BH), .MIN_YELLOW(MY), .ALL_RED_CYC(AR)) dut (
    .clk(clk), .rst_n(rst_n), .main_light(main_light), .side_light(side_light),
    .fault_clr(fault_clr), .main_lamp(main_lamp), .side_lamp(side_lamp),
    .fault(fault), .fault_cause(fault_cause)
  );

  assign obs = {main_lamp, side_lamp, fault, fault_cause};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = all-red startup, 1 = tracking, 2 = faulted.
  int         md;
  int         su_left;
  int         age;
  int         mq, sq;
  int         my_run, sy_run;
  logic [2:0] mcause;

  function automatic logic [2:0] dec(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  // Legal light steps: R->R, R->G, G->G, G->Y, Y->Y, and Y->R after MY yellow cycles.
  function automatic logic bad_step(input int prev, input int nw, input int run);
    if (nw == 3) return 1'b0;
    if (prev == 0) return !(nw == 0 || nw == 2);
    if (prev == 2) return !(nw == 2 || nw == 1);
    return !(nw == 1 || (nw == 0 && run >= MY));
  endfunction

  function automatic logic [9:0] exp_vec();
    logic on;
    if (md == 2) begin
      on = ((age / BH) % 2) == 0;
      return {on ? FM : 3'b000, on ? FS : 3'b000, 1'b1, mcause};
    end
    return {dec(mq), dec(sq), 1'b0, 3'b000};
  endfunction

  task automatic model_reset();
    md = 0; su_left = AR; age = 0;
    mq = 0; sq = 0; my_run = 0; sy_run = 0; mcause = 3'b000;
  endtask

  task automatic model_edge(input int m, input int s, input bit clr);
    logic [2:0] c;
    case (md)
      0: begin
        su_left--;
        if (su_left == 0) md = 1;
      end
      1: begin
        c[0] = (m != 0) && (s != 0);
        c[1] = (m == 3) || (s == 3);
        c[2] = bad_step(mq, m, my_run) || bad_step(sq, s, sy_run);
        if (c != 3'b000) begin
          md = 2; age = 0; mcause = c;
        end else begin
          my_run = (m == 1) ? ((mq == 1) ? my_run + 1 : 1) : 0;
          sy_run = (s == 1) ? ((sq == 1) ? sy_run + 1 : 1) : 0;
          mq = m; sq = s;
        end
      end
      default: begin
        if (clr) model_reset();
        else age++;
      end
    endcase
  endtask

  // Called at a falling edge: apply inputs, advance the model, move to the next falling edge.
  task automatic drive(input int m, input int s, input bit clr);
    main_light = 2'(m);
    side_light = 2'(s);
    fault_clr  = clr;
    model_edge(m, s, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic recover();
    if (md == 2) drive(0, 0, 1);
    for (int i = 0; i < 10 && md != 1; i++) drive(0, 0, 0);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (obs !== 10'b100_100_0_000) begin
      n_bad++; $display("FAIL reset_state got=%b exp=%b", obs, 10'b100_100_0_000);
    end
    rst_n = 1'b1;
    drive(2, 0, 1);
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL startup_clr_ignored got=%b exp=%b", obs, exp_vec());
    end
    drive(2, 0, 0);
    n_cmp++;
    if (obs !== 10'b100_100_0_000) begin
      n_bad++; $display("FAIL startup_all_red got=%b exp=%b", obs, 10'b100_100_0_000);
    end
  endtask

  task automatic test_sequence();
    int seqm[6] = '{2, 1, 0, 0, 0, 0};
    int seqs[6] = '{0, 0, 0, 2, 1, 0};
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 10; i++) begin
        drive(seqm[k], seqs[k], 0);
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_bad++; $display("FAIL sequence seg=%0d cyc=%0d got=%b exp=%b", k, i, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_conflict();
    recover();
    drive(2, 2, 0);
    n_cmp++;
    if (fault_cause !== 3'b001 || fault !== 1'b1) begin
      n_bad++; $display("FAIL conflict_cause got=%b/%b exp=1/001", fault, fault_cause);
    end
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), 0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL conflict_flash cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_causes();
    recover();
    drive(0, 3, 0);
    n_cmp++;
    if (fault_cause !== 3'b010) begin
      n_bad++; $display("FAIL cause_illegal got=%b exp=010", fault_cause);
    end
    recover();
    drive(2, 0, 0);
    drive(0, 0, 0);
    n_cmp++;
    if (fault_cause !== 3'b100 || main_lamp !== FM) begin
      n_bad++; $display("FAIL cause_g_to_r got=%b/%b exp=100/%b", fault_cause, main_lamp, FM);
    end
    recover();
    drive(3, 2, 0);
    n_cmp++;
    if (obs !== exp_vec() || fault_cause !== 3'b011) begin
      n_bad++; $display("FAIL cause_multi got=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_min_yellow();
    recover();
    drive(2, 0, 0);
    repeat (MY - 1) drive(1, 0, 0);
    drive(0, 0, 0);
    n_cmp++;
    if (fault !== 1'b1 || fault_cause !== 3'b100) begin
      n_bad++; $display("FAIL early_y_to_r got=%b/%b exp=1/100", fault, fault_cause);
    end
    recover();
    drive(2, 0, 0);
    repeat (MY) drive(1, 0, 0);
    drive(0, 0, 0);
    n_cmp++;
    if (fault !== 1'b0 || main_lamp !== 3'b100) begin
      n_bad++; $display("FAIL full_y_to_r got=%b/%b exp=0/100", fault, main_lamp);
    end
  endtask

  task automatic test_clear();
    recover();
    drive(3, 0, 0);
    repeat (3) drive(0, 0, 0);
    drive(0, 0, 1);
    n_cmp++;
    if (fault !== 1'b0 || fault_cause !== 3'b000 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL clear got=%b exp=%b", obs, exp_vec());
    end
    for (int i = 0; i < AR; i++) begin
      drive(2, 0, 1);
      n_cmp++;
      if (obs !== 10'b100_100_0_000) begin
        n_bad++; $display("FAIL clear_all_red cyc=%0d got=%b exp=%b", i, obs, 10'b100_100_0_000);
      end
    end
    drive(2, 0, 0);
    n_cmp++;
    if (main_lamp !== 3'b001 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL clear_resume got=%b exp=%b", obs, exp_vec());
    end
    drive(2, 0, 1);
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL clr_in_normal got=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    recover();
    drive(0, 3, 0);
    repeat (BH + 1) drive(0, 0, 0);
    n_cmp++;
    if (main_lamp !== 3'b000 || fault !== 1'b1) begin
      n_bad++; $display("FAIL off_phase got=%b/%b exp=000/1", main_lamp, fault);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (obs !== 10'b100_100_0_000 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL async_reset got=%b exp=%b", obs, 10'b100_100_0_000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int lm = 0, ls = 0;
    bit clr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) >= 70) lm = $urandom_range(0, 3);
      if ($urandom_range(0, 99) >= 70) ls = $urandom_range(0, 3);
      clr = (md == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      drive(lm, ls, clr);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL random cyc=%0d in=%0d/%0d clr=%0b got=%b exp=%b",
                          i, lm, ls, clr, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequence();
    test_conflict();
    test_causes();
    test_min_yellow();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
